intersection_arbiter: RTL and testbench

INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/intersection_arbiter_rr_pick.sv | 30 +++
 rtl/intersection_arbiter.sv | 134 +++++++++++++
 tb/tb_intersection_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-signal blocks: approach count,
// controller state encoding and the lamp encoding.
package traffic_pkg;

  localparam int unsigned NUM_APPROACH = 4;
  localparam int unsigned PHASE_W      = $clog2(NUM_APPROACH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LAMP_R = 2'd0,
    LAMP_Y = 2'd1,
    LAMP_G = 2'd2
  } lamp_e;

endpackage

// File: rtl/intersection_arbiter_rr_pick.sv
// Combinational round-robin pick: first set pending bit searched from
// phase+1 upward, wrapping around the approaches.
module rr_pick
  import traffic_pkg::*;
(
  input  logic [NUM_APPROACH-1:0] pending_i,
  input  logic [PHASE_W-1:0]      phase_i,
  output logic [PHASE_W-1:0]      winner_o,
  output logic                    valid_o
);

  logic [PHASE_W-1:0] idx;
  logic               found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    // The final offset wraps back to phase_i itself, so it is searched last.
    for (int unsigned k = 1; k <= NUM_APPROACH; k++) begin
      idx = phase_i + PHASE_W'(k);
      if (!found && pending_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/intersection_arbiter.sv
// Four-approach intersection controller: latches vehicle requests and serves
// them one green phase at a time in round-robin order with yellow/all-red.
module intersection_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MAX_GREEN   = 10,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_APPROACH-1:0] req,
  output logic [NUM_APPROACH-1:0] green,
  output logic [NUM_APPROACH-1:0] yellow,
  output logic [NUM_APPROACH-1:0] red,
  output logic [PHASE_W-1:0]      phase,
  output logic                    busy
);

  localparam int unsigned EW   = $clog2(MAX_GREEN + 1);
  localparam int unsigned TMAX = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_e                  state_q, state_d;
  logic [NUM_APPROACH-1:0] pending_q, pending_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [EW-1:0]           elapsed_q, elapsed_d;
  logic [TW-1:0]           timer_q, timer_d;

  logic [PHASE_W-1:0]      winner;
  logic                    win_valid;
  logic                    grant;
  logic                    other;
  logic [NUM_APPROACH-1:0] phase_mask;
  logic [NUM_APPROACH-1:0] serve_mask;
  logic [NUM_APPROACH-1:0] grant_mask;
  lamp_e                   lamp [NUM_APPROACH];

  rr_pick u_rr_pick (
    .pending_i (pending_q),
    .phase_i   (phase_q),
    .winner_o  (winner),
    .valid_o   (win_valid)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      phase_q   <= PHASE_W'(NUM_APPROACH - 1);
      elapsed_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      phase_q   <= phase_d;
      elapsed_q <= elapsed_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state, timers and request latching
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    elapsed_d  = elapsed_q;
    timer_d    = timer_q;
    grant      = 1'b0;
    phase_mask = NUM_APPROACH'(1) << phase_q;
    serve_mask = (state_q == ST_GREEN) ? phase_mask : '0;
    other      = |(pending_q & ~phase_mask);

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) grant = 1'b1;
      end
      ST_GREEN: begin
        if (other && (elapsed_q >= EW'(MIN_GREEN - 1)) &&
            (!req[phase_q] || (elapsed_q == EW'(MAX_GREEN - 1)))) begin
          state_d = ST_YELLOW;
          timer_d = '0;
        end else if (elapsed_q != EW'(MAX_GREEN - 1)) begin
          elapsed_d = elapsed_q + EW'(1);
        end
      end
      ST_YELLOW: begin
        if (timer_q == TW'(YELLOW_TIME - 1)) begin
          state_d = ST_ALLRED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ALLRED: begin
        if (timer_q == TW'(ALLRED_TIME - 1)) begin
          if (win_valid) grant = 1'b1;
          else           state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d   = ST_GREEN;
      phase_d   = winner;
      elapsed_d = '0;
    end

    // A grant clears its own bit even if the request is still held.
    grant_mask = grant ? (NUM_APPROACH'(1) << winner) : '0;
    pending_d  = (pending_q | (req & ~serve_mask)) & ~grant_mask;
  end

  // Lamp and status decode from registered state only
  always_comb begin
    for (int unsigned i = 0; i < NUM_APPROACH; i++) begin
      lamp[i] = LAMP_R;
      if (PHASE_W'(i) == phase_q) begin
        if (state_q == ST_GREEN)  lamp[i] = LAMP_G;
        if (state_q == ST_YELLOW) lamp[i] = LAMP_Y;
      end
      green[i]  = (lamp[i] == LAMP_G);
      yellow[i] = (lamp[i] == LAMP_Y);
      red[i]    = (lamp[i] == LAMP_R);
    end
    phase = phase_q;
    busy  = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Bench for intersection_arbiter: a reference model feeds an expected-output
// queue per clock, a monitor drains it; directed scenarios plus random traffic.
module tb_intersection_arbiter;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL   = 2;
  localparam int AR    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] green, yellow, red;
  logic [1:0] phase;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  intersection_arbiter #(
    .MIN_GREEN   (MIN_G),
    .MAX_GREEN   (MAX_G),
    .YELLOW_TIME (YEL),
    .ALLRED_TIME (AR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .green  (green),
    .yellow (yellow),
    .red    (red),
    .phase  (phase),
    .busy   (busy)
  );

  // Reference model: mode 0 idle, 1 green, 2 yellow, 3 all-red.
  int m_mode = 0;
  int m_cur  = 3;
  int m_age  = 0;
  int m_left = 0;
  bit m_pend [4];
  logic [14:0] exp_q [$];

  function automatic int m_pick();
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (m_cur + k) % 4;
      if (m_pend[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cur = 3; m_age = 0; m_left = 0;
    for (int j = 0; j < 4; j++) m_pend[j] = 1'b0;
  endtask

  task automatic m_step(input logic [3:0] r);
    bit np [4];
    int grant;
    bit other;
    grant = -1;
    other = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j != m_cur && m_pend[j]) other = 1'b1;
      np[j] = m_pend[j] | (r[j] && !(m_mode == 1 && m_cur == j));
    end
    case (m_mode)
      0: grant = m_pick();
      1: begin
        if (other && m_age >= MIN_G - 1 && (!r[m_cur] || m_age >= MAX_G - 1)) begin
          m_mode = 2; m_left = YEL;
        end else if (m_age < MAX_G - 1) begin
          m_age++;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_mode = 3; m_left = AR; end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          grant = m_pick();
          if (grant < 0) m_mode = 0;
        end
      end
    endcase
    if (grant >= 0) begin
      m_mode = 1; m_cur = grant; m_age = 0; np[grant] = 1'b0;
    end
    for (int j = 0; j < 4; j++) m_pend[j] = np[j];
  endtask

  function automatic logic [14:0] m_out();
    logic [3:0] g, y, r;
    for (int j = 0; j < 4; j++) begin
      g[j] = (m_mode == 1 && m_cur == j);
      y[j] = (m_mode == 2 && m_cur == j);
      r[j] = !(g[j] || y[j]);
    end
    return {g, y, r, 2'(m_cur), (m_mode != 0)};
  endfunction

  // Model steps on the same edge the DUT does and queues its expectation.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
      exp_q.delete();
    end else begin
      m_step(req);
      exp_q.push_back(m_out());
    end
  end

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      logic [14:0] e;
      logic [14:0] got;
      e   = exp_q.pop_front();
      got = {green, yellow, red, phase, busy};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 $time, got[14:11], got[10:7], got[6:3], got[2:1], got[0],
                 e[14:11], e[10:7], e[6:3], e[2:1], e[0]);
      end
      for (int j = 0; j < 4; j++) begin
        checks++;
        if ((32'(green[j]) + 32'(yellow[j]) + 32'(red[j])) != 1) begin
          errors++;
          $display("FAIL one_lamp approach %0d t=%0t got g=%b y=%b r=%b want exactly one",
                   j, $time, green[j], yellow[j], red[j]);
        end
      end
    end
  end

  task automatic chk_lamps(input string name, input logic [3:0] g, input logic [3:0] y,
                           input logic [3:0] r);
    checks++;
    if (green !== g || yellow !== y || red !== r) begin
      errors++;
      $display("FAIL %s t=%0t got g=%b y=%b r=%b want g=%b y=%b r=%b",
               name, $time, green, yellow, red, g, y, r);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic wait_lamp(input string name, input int which, input logic [3:0] target,
                           input int bound);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < bound && !hit; n++) begin
      @(negedge clk);
      case (which)
        0:       hit = (green == target);
        1:       hit = (yellow == target);
        default: hit = (red == target);
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s timeout after %0d cycles got g=%b y=%b r=%b want %b",
               name, bound, green, yellow, red, target);
    end
  endtask

  task automatic next_green(input string name, input logic [3:0] prev, input int bound,
                            output logic [3:0] got);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < bound && !hit; n++) begin
      @(negedge clk);
      hit = (green != 4'b0000 && green != prev);
    end
    got = green;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s timeout after %0d cycles got green=%b want a new green", name, bound, green);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] got;
    int n;

    // Contention from reset: 0 then 2
    repeat (2) @(negedge clk);
    chk_lamps("reset_lamps", 4'b0000, 4'b0000, 4'b1111);
    checks++;
    if (busy !== 1'b0 || phase !== 2'd3) begin
      errors++;
      $display("FAIL reset_status got busy=%b phase=%0d want busy=0 phase=3", busy, phase);
    end
    #2 rst = 1'b0;
    req = 4'b0101;
    @(negedge clk);
    req = 4'b0000;
    chk_lamps("contend_pending_only", 4'b0000, 4'b0000, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_lamps("contend_green0", 4'b0001, 4'b0000, 4'b1110);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_lamps("contend_yellow0", 4'b0000, 4'b0001, 4'b1110);
    end
    @(negedge clk);
    chk_lamps("contend_allred", 4'b0000, 4'b0000, 4'b1111);
    @(negedge clk);
    chk_lamps("contend_green2", 4'b0100, 4'b0000, 4'b1011);

    // Single pulse on approach 2 rests in green
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    chk4("single_not_yet_green", green, 4'b0000);
    @(negedge clk);
    chk4("single_green_n_plus_1", green, 4'b0100);
    repeat (25) @(negedge clk);
    chk4("single_rest_in_green", green, 4'b0100);

    // Reset mid-green acts without a clock edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_lamps("async_reset_lamps", 4'b0000, 4'b0000, 4'b1111);
    checks++;
    if (busy !== 1'b0 || phase !== 2'd3) begin
      errors++;
      $display("FAIL async_reset_status got busy=%b phase=%0d want busy=0 phase=3", busy, phase);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_lamps("after_reset_idle", 4'b0000, 4'b0000, 4'b1111);

    // Max-out: approach 0 held, approach 1 arrives on first green cycle
    do_reset();
    req = 4'b0001;
    wait_lamp("maxout_wait_green0", 0, 4'b0001, 5);
    req = 4'b0011;
    n = 1;
    for (int k = 0; k < 30 && green[0]; k++) begin
      @(negedge clk);
      if (green[0]) n++;
    end
    checks++;
    if (n != MAX_G) begin
      errors++;
      $display("FAIL maxout_green_len got %0d cycles want %0d", n, MAX_G);
    end
    chk_lamps("maxout_yellow_a", 4'b0000, 4'b0001, 4'b1110);
    @(negedge clk);
    chk_lamps("maxout_yellow_b", 4'b0000, 4'b0001, 4'b1110);
    @(negedge clk);
    chk_lamps("maxout_allred", 4'b0000, 4'b0000, 4'b1111);
    @(negedge clk);
    chk_lamps("maxout_green1", 4'b0010, 4'b0000, 4'b1101);
    req = 4'b0000;
    repeat (20) @(negedge clk);

    // Re-request during own yellow while approach 3 waits
    do_reset();
    req = 4'b1001;
    @(negedge clk);
    req = 4'b0000;
    wait_lamp("rereq_green0", 0, 4'b0001, 5);
    wait_lamp("rereq_yellow0", 1, 4'b0001, 10);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    next_green("rereq_next", 4'b0000, 10, got);
    chk4("rereq_serves_3", got, 4'b1000);
    next_green("rereq_after3", 4'b1000, 20, got);
    chk4("rereq_serves_0", got, 4'b0001);
    repeat (10) @(negedge clk);

    // Random traffic with occasional resets
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        req = 4'($urandom) & 4'($urandom);
      end
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
